avl_pkt_source: RTL and testbench

Avalon-ST packet source that builds the framed packets consumed by the team's FIR filter path. It collects raw ADC samples from a valid-only stream into a small FIFO and wraps them into packets. Each packet is a three-word header (sensor type, scan count high, scan count low), PKT_LEN data words and a trailing error word. It sits upstream of the filter and fully honours sink back-pressure.

---
 rtl/avl_pkt_pkg.sv | 9 +
 rtl/avl_pkt_fifo.sv | 43 ++++
 rtl/avl_pkt_source.sv | 132 +++++++++++++
 tb/tb_avl_pkt_source.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/avl_pkt_pkg.sv
// avl_pkt_pkg: FSM states, header word indices and error-word bit positions for avl_pkt_source
package avl_pkt_pkg;
  typedef enum logic [2:0] {IDLE, HDR_TYPE, HDR_CNT_HI, HDR_CNT_LO, DATA, ERR} state_t;
  localparam int SENSOR_TYPE_PART = 0;
  localparam int SCAN_COUNT_FIRST_PART = 1;
  localparam int SCAN_COUNT_SECOND_PART = 2;
  localparam int ERR_OVF_BIT = 0;
  localparam int DROP_CNT_LSB = 8;
endpackage

// File: rtl/avl_pkt_fifo.sv
// avl_pkt_fifo: synchronous sample FIFO with a fall-through read port
//   clk, reset_n (async, active-low)
//   push/wdata: write side; a push while full is accepted only if a pop happens in the same cycle
//   pop/rdata : read side; rdata shows the head word whenever empty=0
//   full, empty, count: occupancy status
module avl_pkt_fifo
  import avl_pkt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/avl_pkt_source.sv
// avl_pkt_source: frames ADC samples into Avalon-ST packets (3 header words, PKT_LEN data words, error word)
//   clk, reset_n (async, active-low); enable gates the start of new packets
//   sensor_type: header word 0, captured when a packet starts
//   sample_valid/sample_data: valid-only sample stream into the FIFO (no back-pressure)
//   data_output_*: Avalon-ST source, readyLatency 0, all outputs registered
//   busy: high from packet start until the eop transfer
//   AVL_PKT_DROP_CNT_EN: when defined, error word bits [15:8] carry a saturating drop count
module avl_pkt_source
  import avl_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sensor_type,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  data_output_ready,
  output logic                  data_output_valid,
  output logic                  data_output_startofpacket,
  output logic                  data_output_endofpacket,
  output logic [DATA_WIDTH-1:0] data_output_data,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_LEN + 1);
  state_t state;
  logic [31:0] scan_cnt;
  logic [CW-1:0] dcnt;
  logic ovf, load_data, err_load, pop, drop;
  logic fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata, err_word;
`ifdef AVL_PKT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  avl_pkt_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(sample_valid),
    .wdata(sample_data),
    .pop(pop),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // A data word is pulled into the output register when the register frees up
  // (or the last header word leaves) and the packet still needs data.
  always_comb begin
    load_data = (state == HDR_CNT_LO && data_output_ready) ||
                (state == DATA && (!data_output_valid || data_output_ready) && dcnt != CW'(PKT_LEN));
    err_load = state == DATA && data_output_ready && dcnt == CW'(PKT_LEN);
    pop = load_data && !fifo_empty;
    drop = sample_valid && fifo_full && !pop;
    err_word = '0;
    err_word[ERR_OVF_BIT] = ovf;
`ifdef AVL_PKT_DROP_CNT_EN
    err_word[DROP_CNT_LSB +: 8] = drop_cnt;
`endif
  end
  // The error word is frozen in the output register while it waits for ready,
  // so the sticky flags restart when it is loaded; any drop from that cycle on
  // is reported with the next packet.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf <= 1'b0;
    else ovf <= drop || (ovf && !err_load);
`ifdef AVL_PKT_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_cnt <= '0;
    else drop_cnt <= err_load ? 8'(drop) : drop_cnt + 8'(drop && drop_cnt != 8'hFF);
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      data_output_valid <= 1'b0;
      data_output_startofpacket <= 1'b0;
      data_output_endofpacket <= 1'b0;
      data_output_data <= '0;
      busy <= 1'b0;
      scan_cnt <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (enable && fifo_count != '0) begin
            state <= HDR_TYPE;
            data_output_valid <= 1'b1;
            data_output_startofpacket <= 1'b1;
            data_output_data <= sensor_type;
            busy <= 1'b1;
            dcnt <= '0;
          end
        HDR_TYPE:
          if (data_output_ready) begin
            state <= HDR_CNT_HI;
            data_output_startofpacket <= 1'b0;
            data_output_data <= DATA_WIDTH'(scan_cnt[31:16]);
          end
        HDR_CNT_HI:
          if (data_output_ready) begin
            state <= HDR_CNT_LO;
            data_output_data <= DATA_WIDTH'(scan_cnt[15:0]);
          end
        HDR_CNT_LO, DATA:
          if (load_data) begin
            state <= DATA;
            data_output_valid <= !fifo_empty;
            if (!fifo_empty) begin
              data_output_data <= fifo_rdata;
              dcnt <= dcnt + 1'b1;
            end
          end else if (err_load) begin
            state <= ERR;
            data_output_endofpacket <= 1'b1;
            data_output_data <= err_word;
          end
        ERR:
          if (data_output_ready) begin
            state <= IDLE;
            data_output_valid <= 1'b0;
            data_output_endofpacket <= 1'b0;
            busy <= 1'b0;
            scan_cnt <= scan_cnt + 32'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_avl_pkt_source.sv
// tb_avl_pkt_source: scoreboard bench; a packet-level model queues expected words, a monitor checks every transfer
`timescale 1ns/1ps
module tb_avl_pkt_source;
  localparam int DW = 16, PL = 4, FD = 16;
  logic clk = 0, reset_n = 0, enable = 0, sample_valid = 0, ready = 0;
  logic [DW-1:0] sensor_type = '0, sample_data = '0, odata;
  logic ovalid, osop, oeop, busy;
  avl_pkt_source #(.DATA_WIDTH(DW), .PKT_LEN(PL), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .sensor_type(sensor_type),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .data_output_ready(ready),
    .data_output_valid(ovalid),
    .data_output_startofpacket(osop),
    .data_output_endofpacket(oeop),
    .data_output_data(odata),
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic sop; logic eop; logic isdata; logic [DW-1:0] data;} word_t;
  word_t eq[$];
  word_t ew, hw;
  logic [DW-1:0] sq[$];
  logic [31:0] scan = '0;
  int vectors = 0, errors = 0, pend_drops = 0, sent = 0, xfer = 0, cyc = 0, sop_cyc = 0, rmode = 0;
  bit chk_len = 0, held = 0;

  function automatic logic [DW-1:0] err_of(int d);
    logic [DW-1:0] w = '0;
    w[0] = d > 0;
`ifdef AVL_PKT_DROP_CNT_EN
    w[15:8] = d > 255 ? 8'hFF : 8'(d);
`endif
    return w;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One packet per PL buffered samples: header, data in arrival order, error word.
  task automatic packetize(int n);
    repeat (n) if (sq.size() >= PL) begin
      eq.push_back('{1'b1, 1'b0, 1'b0, sensor_type});
      eq.push_back('{1'b0, 1'b0, 1'b0, DW'(scan[31:16])});
      eq.push_back('{1'b0, 1'b0, 1'b0, DW'(scan[15:0])});
      repeat (PL) eq.push_back('{1'b0, 1'b0, 1'b1, sq.pop_front()});
      eq.push_back('{1'b0, 1'b1, 1'b0, err_of(pend_drops)});
      pend_drops = 0;
      scan = scan + 32'd1;
    end
  endtask

  // fc=1 throttles so unsent-out samples never reach FD (no drops);
  // fc=0 is only used with ready low, where exactly the first FD samples fit.
  task automatic burst(int n, int gap, bit fc, int npk);
    logic [DW-1:0] d[$];
    int keep;
    for (int i = 0; i < n; i++) d.push_back(DW'($urandom));
    keep = (fc || n <= FD) ? n : FD;
    for (int i = 0; i < keep; i++) sq.push_back(d[i]);
    pend_drops += n - keep;
    packetize(npk);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (fc && sent - xfer >= FD && w < 500) begin tick(); w++; end
      sample_valid = 1;
      sample_data = d[i];
      if (i < keep) sent++;
      tick();
      sample_valid = 0;
      repeat ($urandom_range(0, gap)) tick();
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((eq.size() != 0 || busy || ovalid) && n < 2000) begin tick(); n++; end
    check({name, " words left"}, 64'(eq.size()), 0);
    check({name, " busy after"}, busy, 0);
    eq.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~ready : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (!reset_n) held = 0;
    else begin
      if (held) check("held word", {ovalid, osop, oeop, odata}, {1'b1, hw.sop, hw.eop, hw.data});
      if (ovalid && ready) begin
        if (eq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected word: got sop=%0b eop=%0b data=%0h, expected none", osop, oeop, odata);
        end else begin
          ew = eq.pop_front();
          check("word", {osop, oeop, odata}, {ew.sop, ew.eop, ew.data});
          if (ew.isdata) xfer++;
          if (osop) sop_cyc = cyc;
          if (oeop && chk_len) check("packet cycles", 64'(cyc - sop_cyc), PL + 3);
        end
      end
      held = ovalid && !ready;
      hw = '{osop, oeop, 1'b0, odata};
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    sensor_type = 16'hA5C3;
    repeat (3) tick();
    check("reset valid", ovalid, 0);
    check("reset sop/eop", {osop, oeop}, 0);
    check("reset busy", busy, 0);
    check("reset data", odata, 0);
    reset_n = 1;
    enable = 1;
    rmode = 0;
    repeat (2) tick();
    // basic: samples 1..PL back to back, ready high
    for (int i = 1; i <= PL; i++) sq.push_back(DW'(i));
    sent += PL;
    packetize(1);
    chk_len = 1;
    for (int i = 1; i <= PL; i++) begin
      sample_valid = 1;
      sample_data = DW'(i);
      tick();
      if (i == 1) check("latency n+1 idle", ovalid, 0);
      if (i == 2) check("latency n+2 sop", {ovalid, osop}, 2'b11);
    end
    sample_valid = 0;
    drain("basic");
    chk_len = 0;
    // ready toggling every cycle; header carries scan count 1
    rmode = 1;
    burst(PL, 0, 1, 1);
    drain("toggle");
    // ready low while 20 samples arrive: FD kept, the rest dropped
    rmode = 3;
    repeat (2) tick();
    burst(20, 0, 0, FD / PL);
    repeat (20) tick();
    rmode = 0;
    drain("overflow");
    // scan count wrap
    force dut.scan_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.scan_cnt;
    scan = 32'hFFFF_FFFF;
    rmode = 2;
    sensor_type = DW'($urandom);
    burst(2 * PL, 1, 1, 2);
    drain("wrap");
    // enable dropped during DATA
    rmode = 0;
    fork
      burst(2 * PL, 0, 1, 1);
      begin repeat (7) tick(); enable = 0; end
    join
    drain("enable off");
    repeat (20) begin
      tick();
      check("no start while disabled", {ovalid, busy}, 0);
    end
    enable = 1;
    packetize(1);
    drain("enable on");
    // reset pulse mid-DATA
    burst(PL, 0, 1, 1);
    repeat (2) tick();
    #2;
    reset_n = 0;
    #1;
    check("async reset valid", ovalid, 0);
    check("async reset busy/sop/eop", {busy, osop, oeop}, 0);
    eq.delete();
    sq.delete();
    scan = '0;
    sent = 0;
    xfer = 0;
    pend_drops = 0;
    @(posedge clk);
    #3;
    reset_n = 1;
    repeat (5) begin
      tick();
      check("post-reset idle", {ovalid, busy}, 0);
    end
    burst(PL, 0, 1, 1);
    drain("after reset");
    // randomized traffic
    rmode = 2;
    sensor_type = DW'($urandom);
    burst(6 * PL, 3, 1, 6);
    drain("random gaps");
    sensor_type = DW'($urandom);
    burst(4 * PL, 0, 1, 4);
    drain("random dense");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
